// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle MIPS-32 main control FSM
// Optional addi support is compiled in when MC_ADDI_EN is defined.
module multicycle_main_control #(
  parameter logic [5:0] OPC_RTYPE = 6'b000000,
  parameter logic [5:0] OPC_LW    = 6'b100011,
  parameter logic [5:0] OPC_SW    = 6'b101011,
  parameter logic [5:0] OPC_BEQ   = 6'b000100,
  parameter logic [5:0] OPC_J     = 6'b000010,
  parameter logic [5:0] OPC_ADDI  = 6'b001000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCEn,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t state_q, state_d;
  // The lw/sw choice is captured in DECODE so later Opcode changes cannot redirect MEMADR.
  logic   is_load_q, is_load_d;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_raw;
  logic [1:0] alu_src_b, alu_op, pc_source;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    is_load_d     = is_load_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_raw   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        is_load_d = (Opcode == OPC_LW);
        if (Opcode == OPC_LW || Opcode == OPC_SW) begin
          state_d = S_MEMADR;
        end else if (Opcode == OPC_RTYPE) begin
          state_d = S_EXEC;
        end else if (Opcode == OPC_BEQ) begin
          state_d = S_BRANCH;
        end else if (Opcode == OPC_J) begin
          state_d = S_JUMP;
`ifdef MC_ADDI_EN
        end else if (Opcode == OPC_ADDI) begin
          state_d = S_ADDIEX;
`else
        end else if (Opcode == OPC_ADDI) begin
          state_d     = S_FETCH;
          illegal_raw = 1'b1;
`endif
        end else begin
          state_d     = S_FETCH;
          illegal_raw = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = is_load_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Gating with reset_n keeps every enable low while reset is held, even though state_q is FETCH.
  assign PCWrite     = reset_n & pc_write;
  assign PCWriteCond = reset_n & pc_write_cond;
  assign PCEn        = reset_n & (pc_write | (pc_write_cond & Zero));
  assign IorD        = reset_n & iord;
  assign MemRead     = reset_n & mem_read;
  assign MemWrite    = reset_n & mem_write;
  assign IRWrite     = reset_n & ir_write;
  assign MemtoReg    = reset_n & mem_to_reg;
  assign RegDst      = reset_n & reg_dst;
  assign RegWrite    = reset_n & reg_write;
  assign ALUSrcA     = reset_n & alu_src_a;
  assign ALUSrcB     = reset_n ? alu_src_b : 2'b00;
  assign ALUOp       = reset_n ? alu_op : 2'b00;
  assign PCSource    = reset_n ? pc_source : 2'b00;
  assign state       = reset_n ? state_q : 4'd0;
  assign illegal_op  = reset_n & illegal_raw;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - self-checking bench for multicycle_main_control
// Table of instruction vectors, hand sequences for reset/stall corners, random run against a path model.
module tb_multicycle_main_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       mem_ready;
  logic       PCEn, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  always #5 clock = ~clock;

  multicycle_main_control dut (
    .clock(clock), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCEn(PCEn), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .illegal_op(illegal_op)
  );

  // Bit map: 21 PCEn, 20 PCWrite, 19 PCWriteCond, 18 IorD, 17 MemRead, 16 MemWrite, 15 IRWrite,
  // 14 MemtoReg, 13 RegDst, 12 RegWrite, 11 ALUSrcA, 10:9 ALUSrcB, 8:7 ALUOp, 6:5 PCSource, 4:1 state, 0 illegal_op
  logic [21:0] obs;
  assign obs = {PCEn, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegal_op};

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit addi_enabled();
`ifdef MC_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_legal(input logic [5:0] opc);
    return opc == OP_R || opc == OP_LW || opc == OP_SW || opc == OP_BEQ || opc == OP_J ||
           (opc == OP_ADDI && addi_enabled());
  endfunction

  // Expected outputs of each state, straight from the per-state control listing.
  function automatic logic [21:0] model_out(input int st, input bit mr, input bit z, input bit ill);
    bit pcen, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    bit [1:0] asb, aop, pcs;
    {pcen, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'd0; aop = 2'd0; pcs = 2'd0;
    case (st)
      0:  begin mrd = 1; asb = 2'd1; pcw = mr; irw = mr; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'd2; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; end
      9:  begin pcw = 1; pcs = 2'd2; end
      10: begin asa = 1; asb = 2'd2; end
      11: rw = 1;
      default: ;
    endcase
    pcen = pcw | (pcwc & z);
    return {pcen, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, 4'(st), ill};
  endfunction

  int path[$];
  task automatic build_path(input logic [5:0] opc);
    path = '{0, 1};
    if (opc == OP_LW)      path = '{0, 1, 2, 3, 4};
    else if (opc == OP_SW) path = '{0, 1, 2, 5};
    else if (opc == OP_R)  path = '{0, 1, 6, 7};
    else if (opc == OP_BEQ) path = '{0, 1, 8};
    else if (opc == OP_J)  path = '{0, 1, 9};
    else if (opc == OP_ADDI && addi_enabled()) path = '{0, 1, 10, 11};
  endtask

  int          trace[$];
  logic [21:0] obs_q[$];
  int cnt_regw, cnt_pcen, cnt_ill, cnt_memw;

  // Runs one instruction from FETCH; stall_n cycles of mem_ready=0 are applied in state stall_st.
  task automatic run_instr(input string nm, input logic [5:0] opc, input logic z,
                           input int stall_st, input int stall_n);
    int  stalls;
    bit  done;
    stalls = 0; done = 0;
    trace.delete(); obs_q.delete();
    cnt_regw = 0; cnt_pcen = 0; cnt_ill = 0; cnt_memw = 0;
    Opcode = opc; Zero = z;
    for (int c = 0; c < 30; c++) begin
      mem_ready = !(int'(state) == stall_st && stalls < stall_n);
      if (!mem_ready) stalls++;
      @(negedge clock);
      trace.push_back(int'(state));
      obs_q.push_back(obs);
      cnt_regw += int'(RegWrite);
      cnt_pcen += int'(PCEn);
      cnt_ill  += int'(illegal_op);
      cnt_memw += int'(MemWrite);
      @(posedge clock); #1;
      if (state == 4'd0 && trace[trace.size()-1] != 0) begin
        done = 1;
        break;
      end
    end
    check({nm, "_returns_to_fetch"}, 32'(done), 32'd1);
    mem_ready = 1'b1;
  endtask

  typedef struct {
    logic [5:0] opc;
    logic       z;
    int         cycles;
    int         regw;
    int         pcen;
    int         ill;
    int         memw;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int idx;
    int ncyc;
    bit ill;
    logic [5:0] opc;
    logic [21:0] exp_v;
    bit done;

    reset_n = 1'b0; mem_ready = 1'b1; Opcode = 6'd0; Zero = 1'b0;
    #12;
    check("reset_all_zero", 32'(obs), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    tbl.push_back('{OP_LW,  1'b0, 5, 1, 1, 0, 0});
    tbl.push_back('{OP_SW,  1'b0, 4, 0, 1, 0, 1});
    tbl.push_back('{OP_R,   1'b1, 4, 1, 1, 0, 0});
    tbl.push_back('{OP_BEQ, 1'b1, 3, 0, 2, 0, 0});
    tbl.push_back('{OP_BEQ, 1'b0, 3, 0, 1, 0, 0});
    tbl.push_back('{OP_J,   1'b0, 3, 0, 2, 0, 0});
    tbl.push_back('{6'b111111, 1'b0, 2, 0, 1, 1, 0});
`ifdef MC_ADDI_EN
    tbl.push_back('{OP_ADDI, 1'b0, 4, 1, 1, 0, 0});
`else
    tbl.push_back('{OP_ADDI, 1'b0, 2, 0, 1, 1, 0});
`endif

    foreach (tbl[i]) begin
      run_instr($sformatf("vec%0d", i), tbl[i].opc, tbl[i].z, -1, 0);
      check($sformatf("vec%0d_cycles", i), 32'(trace.size()), 32'(tbl[i].cycles));
      check($sformatf("vec%0d_regwrite", i), 32'(cnt_regw), 32'(tbl[i].regw));
      check($sformatf("vec%0d_pcen", i), 32'(cnt_pcen), 32'(tbl[i].pcen));
      check($sformatf("vec%0d_illegal", i), 32'(cnt_ill), 32'(tbl[i].ill));
      check($sformatf("vec%0d_memwrite", i), 32'(cnt_memw), 32'(tbl[i].memw));
    end

    // lw state trace and per-state controls
    run_instr("lw", OP_LW, 1'b0, -1, 0);
    check("lw_len", 32'(trace.size()), 32'd5);
    if (trace.size() == 5) begin
      for (int k = 0; k < 5; k++) check($sformatf("lw_state%0d", k), 32'(trace[k]), 32'(k));
      check("lw_wb_memtoreg_regwrite", 32'({obs_q[4][14], obs_q[4][12]}), 32'b11);
      check("lw_memadr_aluop", 32'(obs_q[2][8:7]), 32'd0);
      check("lw_fetch_aluop", 32'(obs_q[0][8:7]), 32'd0);
    end

    run_instr("rtype", OP_R, 1'b0, -1, 0);
    if (trace.size() >= 3) check("rtype_exec_aluop", 32'(obs_q[2][8:7]), 32'd2);
    run_instr("beq_z1", OP_BEQ, 1'b1, -1, 0);
    if (trace.size() >= 3) begin
      check("beq_aluop", 32'(obs_q[2][8:7]), 32'd1);
      check("beq_z1_pcen", 32'(obs_q[2][21]), 32'd1);
    end
    run_instr("beq_z0", OP_BEQ, 1'b0, -1, 0);
    if (trace.size() >= 3) check("beq_z0_pcen", 32'(obs_q[2][21]), 32'd0);

    // sw held in MEMWR for 3 extra cycles
    run_instr("sw_stall", OP_SW, 1'b0, 5, 3);
    check("sw_stall_memwrite_cycles", 32'(cnt_memw), 32'd4);
    check("sw_stall_regwrite", 32'(cnt_regw), 32'd0);
    check("sw_stall_cycles", 32'(trace.size()), 32'd7);

    // asynchronous reset in the middle of MEMRD
    Opcode = OP_LW; mem_ready = 1'b1; done = 0;
    for (int c = 0; c < 10; c++) begin
      if (state == 4'd3) begin done = 1; break; end
      @(posedge clock); #1;
    end
    check("reached_memrd", 32'(done), 32'd1);
    mem_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(obs), 32'd0);
    @(posedge clock); #1;
    check("held_reset_outputs", 32'(obs), 32'd0);
    mem_ready = 1'b1;
    reset_n = 1'b1;
    @(negedge clock);
    check("post_reset_irwrite_pcwrite", 32'({IRWrite, PCWrite}), 32'b11);
    check("post_reset_state", 32'(state), 32'd0);
    mem_ready = 1'b0;
    @(posedge clock); #1;

    // Random instructions with random stalls, Zero and post-DECODE Opcode noise
    for (int n = 0; n < 300; n++) begin
      case ($urandom % 7)
        0: opc = OP_R;
        1: opc = OP_LW;
        2: opc = OP_SW;
        3: opc = OP_BEQ;
        4: opc = OP_J;
        5: opc = OP_ADDI;
        default: opc = 6'($urandom);
      endcase
      ill = !is_legal(opc);
      build_path(opc);
      Opcode = opc;
      idx = 0;
      ncyc = 0;
      while (idx < path.size() && ncyc < 40) begin
        mem_ready = ($urandom % 4) != 0;
        Zero = 1'($urandom);
        if (idx >= 2) Opcode = 6'($urandom);
        @(negedge clock);
        exp_v = model_out(path[idx], mem_ready, Zero, ill && path[idx] == 1);
        check($sformatf("rand%0d_cyc%0d", n, ncyc), 32'(obs), 32'(exp_v));
        if (!((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !mem_ready)) idx++;
        ncyc++;
        @(posedge clock); #1;
      end
      check($sformatf("rand%0d_bounded", n), 32'(ncyc < 40), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Main control unit for the multicycle MIPS-32 datapath. It decodes the instruction opcode, sequences the fetch/decode/execute/memory/writeback steps, and drives every datapath select and enable. It also produces `ALUOp[1:0]`, which the ALU-control decoder combines with the funct field to pick the ALU operation. Memory steps stall on a ready handshake.

## Interface
- `OPC_RTYPE`, default 6'b000000: R-type opcode.
- `OPC_LW`, default 6'b100011: load word.
- `OPC_SW`, default 6'b101011: store word.
- `OPC_BEQ`, default 6'b000100: branch if equal.
- `OPC_J`, default 6'b000010: jump.
- `OPC_ADDI`, default 6'b001000: add immediate; used only with `MC_ADDI_EN`.
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `Opcode` in 6: IR[31:26]; valid from DECODE onward.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCEn` out 1: PC load enable, equal to `PCWrite | (PCWriteCond & Zero)`.
- `PCWrite`, `PCWriteCond` out 1 each: unconditional and conditional PC write.
- `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA` out 1 each: standard multicycle controls.
- `ALUSrcB` out 2: 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `ALUOp` out 2: 00 add, 01 subtract, 10 use funct.
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `state` out 4: current state, for debug.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.

## Operation
- Moore FSM with a 4-bit state register. Outputs are combinational from the state; `IRWrite`, `PCWrite`, `PCEn` in FETCH are also gated by `mem_ready`. Signals not listed for a state are 0.
- **0 FETCH**: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready. Stays in FETCH while !mem_ready, else goes to DECODE.
- **1 DECODE**: ALUSrcB=11, ALUOp=00. Next state by opcode:
  - lw or sw: MEMADR.
  - R-type: EXEC.
  - beq: BRANCH.
  - j: JUMP.
  - addi (if enabled): ADDIEX.
  - any other opcode: FETCH, with `illegal_op`=1 for this cycle.
- **2 MEMADR**: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
- **3 MEMRD**: MemRead=1, IorD=1. Holds until mem_ready, then MEMWB.
- **4 MEMWB**: RegWrite=1, MemtoReg=1, RegDst=0. Next is FETCH.
- **5 MEMWR**: MemWrite=1, IorD=1. Holds until mem_ready, then FETCH.
- **6 EXEC**: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- **7 ALUWB**: RegWrite=1, RegDst=1, MemtoReg=0. Next is FETCH.
- **8 BRANCH**: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next is FETCH.
- **9 JUMP**: PCWrite=1, PCSource=10. Next is FETCH.
- **10 ADDIEX**: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDIWB.
- **11 ADDIWB**: RegWrite=1, RegDst=0, MemtoReg=0. Next is FETCH.
- Unused encodings 12-15 go to FETCH on the next edge and drive all outputs 0.
- MemRead and MemWrite are never asserted in the same cycle.

## Timing
- Reset: `state`=0 (FETCH) immediately, asynchronously. While `reset_n`=0, every output is forced to 0, including `MemRead` and `state` bits beyond 0. On release, FETCH outputs resume at the next evaluation.
- Reset mid-instruction abandons the instruction. No write enable may glitch high during reset assertion.
- Cycle counts with `mem_ready` constantly 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle. All outputs hold steady during the stall.
- The `Opcode` sample taken in DECODE decides the path. `Opcode` changes after DECODE have no effect.
- `PCEn` in BRANCH follows the same-cycle `Zero` combinationally.

## Configuration
- `MC_ADDI_EN` defined: the ADDIEX and ADDIWB states exist, and `OPC_ADDI` decodes in DECODE.
- `MC_ADDI_EN` undefined: states 10 and 11 are unused encodings, and opcode 001000 is illegal (FETCH with an `illegal_op` pulse).

## Test plan
- Reset with `reset_n`=0 mid-MEMRD: state goes to 0 asynchronously and all outputs are 0; after release with mem_ready=1, IRWrite=PCWrite=1 in the first cycle.
- lw (Opcode 100011), mem_ready=1: state sequence 0,1,2,3,4,0; MemtoReg=RegWrite=1 only in state 4; ALUOp=00 in states 2 and 0.
- R-type, then beq with Zero=1, then beq with Zero=0:
  - R-type: ALUOp=10 in state 6.
  - beq: ALUOp=01 in state 8.
  - PCEn=1 for the first beq and 0 for the second.
- sw with mem_ready held low for 3 cycles in MEMWR: MemWrite=1 for 4 cycles, then FETCH; no RegWrite.
- Opcode 111111 in DECODE: illegal_op=1 for exactly one cycle, next state 0, no write enables.
- addi (001000): with `MC_ADDI_EN`, state sequence 0,1,10,11,0 and RegWrite=1, RegDst=0 in state 11; without it, illegal_op pulses.
